// File: rtl/lcd_gfx_pkg.sv
// Shared LCD graphics definitions: span-word field layout, sequencer state
// encoding and the span-word pack helper used by producer and consumer.
package lcd_gfx_pkg;

   localparam int SPAN_ADDR_LSB  = 0;
   localparam int SPAN_ADDR_W    = 18;
   localparam int SPAN_COUNT_LSB = 18;
   localparam int SPAN_COUNT_W   = 10;
   localparam int SPAN_PAGE_LSB  = 28;
   localparam int SPAN_PAGE_W    = 2;
   localparam int SPAN_PIXEL_BIT = 30;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_EMIT  = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   function automatic logic [31:0] pack_span(
      input logic                    pixel,
      input logic [SPAN_PAGE_W-1:0]  page,
      input logic [SPAN_COUNT_W-1:0] count,
      input logic [SPAN_ADDR_W-1:0]  addr
   );
      logic [31:0] span;
      span = '0;
      span[SPAN_ADDR_LSB  +: SPAN_ADDR_W]  = addr;
      span[SPAN_COUNT_LSB +: SPAN_COUNT_W] = count;
      span[SPAN_PAGE_LSB  +: SPAN_PAGE_W]  = page;
      span[SPAN_PIXEL_BIT]                 = pixel;
      return span;
   endfunction

endpackage

// File: rtl/lcd_rect_clip.sv
// Combinational clipping of a fill rectangle to the visible screen.
// Clipping is enabled by defining LCD_RECT_FILL_CLIP_EN; otherwise w/h pass through.
module lcd_rect_clip #(
   parameter int g_h_pixels = 320,
   parameter int g_v_pixels = 240
) (
   input  logic [9:0] x_i,
   input  logic [9:0] y_i,
   input  logic [9:0] w_i,
   input  logic [9:0] h_i,
   output logic [9:0] ew_o,
   output logic [9:0] eh_o
);

`ifdef LCD_RECT_FILL_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   localparam logic [10:0] H_LIM = 11'(g_h_pixels);
   localparam logic [10:0] V_LIM = 11'(g_v_pixels);

   logic [10:0] x_end;
   logic [10:0] y_end;

   always_comb begin
      // NOTE: outputs get a default before any branch so no latch is inferred.
      ew_o  = w_i;
      eh_o  = h_i;
      x_end = {1'b0, x_i} + {1'b0, w_i};
      y_end = {1'b0, y_i} + {1'b0, h_i};
      if (CLIP_EN) begin
         if ({1'b0, x_i} >= H_LIM || {1'b0, y_i} >= V_LIM) begin
            ew_o = '0;
            eh_o = '0;
         end else begin
            if (x_end > H_LIM) ew_o = 10'(H_LIM - {1'b0, x_i});
            if (y_end > V_LIM) eh_o = 10'(V_LIM - {1'b0, y_i});
         end
      end
   end

endmodule

// File: rtl/lcd_rect_fill_seq.sv
// Rectangle-fill sequencer: turns one fill command into one span word per row
// for the LCD pixel FIFO. Optional clipping via LCD_RECT_FILL_CLIP_EN.
module lcd_rect_fill_seq
   import lcd_gfx_pkg::*;
#(
   parameter int g_h_pixels   = 320,
   parameter int g_v_pixels   = 240,
   parameter int g_addr_width = 18
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [9:0]  cmd_x_i,
   input  logic [9:0]  cmd_y_i,
   input  logic [9:0]  cmd_w_i,
   input  logic [9:0]  cmd_h_i,
   input  logic [1:0]  cmd_page_i,
   input  logic        cmd_pixel_i,
   output logic        pfifo_we_o,
   output logic [31:0] pfifo_data_o,
   input  logic        pfifo_full_i,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [g_addr_width-1:0] ROW_STRIDE = g_addr_width'(g_h_pixels);

   seq_state_e              state_q, state_d;
   logic [9:0]              x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
   logic [1:0]              page_q, page_d;
   logic                    pixel_q, pixel_d;
   logic [9:0]              ew_q, ew_d, rows_q, rows_d;
   logic [g_addr_width-1:0] addr_q, addr_d, base_addr;
   logic [9:0]              ew_c, eh_c;

   lcd_rect_clip #(
      .g_h_pixels (g_h_pixels),
      .g_v_pixels (g_v_pixels)
   ) u_clip (
      .x_i  (x_q),
      .y_i  (y_q),
      .w_i  (w_q),
      .h_i  (h_q),
      .ew_o (ew_c),
      .eh_o (eh_c)
   );

   // Write strobe stays combinational so a full FIFO is never written.
   assign pfifo_we_o   = (state_q == ST_EMIT) && !pfifo_full_i;
   assign pfifo_data_o = pack_span(pixel_q, page_q, ew_q, SPAN_ADDR_W'(addr_q));
   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = (state_q == ST_DONE);

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      w_d       = w_q;
      h_d       = h_q;
      page_d    = page_q;
      pixel_d   = pixel_q;
      ew_d      = ew_q;
      rows_d    = rows_q;
      addr_d    = addr_q;
      base_addr = g_addr_width'(y_q) * ROW_STRIDE + g_addr_width'(x_q);
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               x_d     = cmd_x_i;
               y_d     = cmd_y_i;
               w_d     = cmd_w_i;
               h_d     = cmd_h_i;
               page_d  = cmd_page_i;
               pixel_d = cmd_pixel_i;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            ew_d    = ew_c;
            rows_d  = eh_c;
            addr_d  = base_addr;
            state_d = (ew_c == '0 || eh_c == '0) ? ST_DONE : ST_EMIT;
         end
         ST_EMIT: begin
            if (pfifo_we_o) begin
               addr_d = addr_q + ROW_STRIDE;
               rows_d = rows_q - 10'd1;
               if (rows_q == 10'd1) state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
      if (rst_i) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         page_q  <= '0;
         pixel_q <= 1'b0;
         ew_q    <= '0;
         rows_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         page_q  <= page_d;
         pixel_q <= pixel_d;
         ew_q    <= ew_d;
         rows_q  <= rows_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: tb/tb_lcd_rect_fill_seq.sv
// Self-checking bench for lcd_rect_fill_seq: directed and random fills checked
// against a span-list model. Define LCD_RECT_FILL_CLIP_EN to match a clipped build.
module tb_lcd_rect_fill_seq;

   localparam int H_PIX = 320;
   localparam int V_PIX = 240;
   localparam int MAXC  = 256;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [9:0]  cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i;
   logic [1:0]  cmd_page_i;
   logic        cmd_pixel_i;
   logic        pfifo_we_o;
   logic [31:0] pfifo_data_o;
   logic        pfifo_full_i;
   logic        busy_o;
   logic        done_o;

   int n_assert = 0;
   int n_fail   = 0;

   // Command queued behind the current one when cmd_valid_i is held high.
   int nxt_x, nxt_y, nxt_w, nxt_h, nxt_page, nxt_pixel;

   always #5 clk = ~clk;

   lcd_rect_fill_seq dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_x_i      (cmd_x_i),
      .cmd_y_i      (cmd_y_i),
      .cmd_w_i      (cmd_w_i),
      .cmd_h_i      (cmd_h_i),
      .cmd_page_i   (cmd_page_i),
      .cmd_pixel_i  (cmd_pixel_i),
      .pfifo_we_o   (pfifo_we_o),
      .pfifo_data_o (pfifo_data_o),
      .pfifo_full_i (pfifo_full_i),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clip(input int x, input int y, input int w, input int h,
                                      output int ew, output int eh);
`ifdef LCD_RECT_FILL_CLIP_EN
      if (x >= H_PIX || y >= V_PIX) begin
         ew = 0;
         eh = 0;
      end else begin
         ew = (w < H_PIX - x) ? w : H_PIX - x;
         eh = (h < V_PIX - y) ? h : V_PIX - y;
      end
`else
      ew = w;
      eh = h;
`endif
   endfunction

   function automatic logic [31:0] exp_word(input int x, input int y, input int ew,
                                            input int page, input int pixel, input int row);
      logic [31:0] a;
      a = 32'(((y + row) * H_PIX + x) % (1 << 18));
      return a | (32'(ew) << 18) | (32'(page) << 28) | (32'(pixel) << 30);
   endfunction

   task automatic drive_cmd(input int x, input int y, input int w, input int h,
                            input int page, input int pixel);
      cmd_x_i     = 10'(x);
      cmd_y_i     = 10'(y);
      cmd_w_i     = 10'(w);
      cmd_h_i     = 10'(h);
      cmd_page_i  = 2'(page);
      cmd_pixel_i = 1'(pixel);
   endtask

   // Entered at posedge+1 with the DUT idle; returns in the cycle ready comes back.
   // mode: 0 no backpressure, 1 full toggles, 2 random full, 3 full for 4 cycles after first word.
   task automatic run_cmd(input string tag, input int x, input int y, input int w, input int h,
                          input int page, input int pixel, input int mode, input bit hold_valid);
      bit          full_pat[MAXC];
      int          exp_cyc[$];
      logic [31:0] got[$];
      int          got_cyc[$];
      int          ew, eh, n_exp, exp_done, done_cnt, done_cyc, ready_cyc;

      model_clip(x, y, w, h, ew, eh);
      n_exp = (ew == 0 || eh == 0) ? 0 : eh;
      for (int c = 0; c < MAXC; c++) begin
         case (mode)
            1:       full_pat[c] = (c % 2) == 1;
            2:       full_pat[c] = 1'($urandom_range(0, 1));
            3:       full_pat[c] = (c >= 3 && c <= 6);
            default: full_pat[c] = 1'b0;
         endcase
      end
      for (int c = 2; c < MAXC && exp_cyc.size() < n_exp; c++)
         if (!full_pat[c]) exp_cyc.push_back(c);
      exp_done = (n_exp == 0) ? 2 : exp_cyc[n_exp-1] + 1;

      done_cnt  = 0;
      done_cyc  = -1;
      ready_cyc = -1;
      for (int c = 0; c < MAXC; c++) begin
         cmd_valid_i = (c == 0) || hold_valid;
         if (c == 0 || !hold_valid) drive_cmd(x, y, w, h, page, pixel);
         else                       drive_cmd(nxt_x, nxt_y, nxt_w, nxt_h, nxt_page, nxt_pixel);
         pfifo_full_i = full_pat[c];
         #1;
         if (c == 0) check({tag, ".ready_at_accept"}, 32'(cmd_ready_o), 32'd1);
         if (busy_o && pfifo_full_i && got.size() > 0 && got.size() < n_exp)
            check({tag, ".held_data"}, pfifo_data_o, exp_word(x, y, ew, page, pixel, got.size()));
         if (pfifo_we_o) begin
            got.push_back(pfifo_data_o);
            got_cyc.push_back(c);
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = c;
         end
         if (c > 0 && cmd_ready_o) begin
            ready_cyc = c;
            break;
         end
         @(posedge clk);
         #1;
      end

      check({tag, ".ready_returned"}, 32'(ready_cyc >= 0), 32'd1);
      check({tag, ".word_count"}, 32'(got.size()), 32'(n_exp));
      for (int i = 0; i < got.size() && i < n_exp; i++) begin
         check({tag, ".word"}, got[i], exp_word(x, y, ew, page, pixel, i));
         check({tag, ".word_cycle"}, 32'(got_cyc[i]), 32'(exp_cyc[i]));
      end
      check({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_done));
      check({tag, ".ready_cycle"}, 32'(ready_cyc), 32'(exp_done + 1));
   endtask

   initial begin
      int rx, ry, rw, rh, rpg, rpx, rmode;
      int rst_words;

      rst_i        = 1'b1;
      cmd_valid_i  = 1'b0;
      pfifo_full_i = 1'b0;
      drive_cmd(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset.ready", 32'(cmd_ready_o), 32'd1);
      check("reset.busy",  32'(busy_o),      32'd0);
      check("reset.done",  32'(done_o),      32'd0);
      check("reset.we",    32'(pfifo_we_o),  32'd0);
      check("reset.data",  pfifo_data_o,     32'd0);
      rst_i = 1'b0;

      run_cmd("basic",        10,  2,  5,  3, 1, 1, 0, 1'b0);
      run_cmd("backpressure", 10,  2,  5,  3, 1, 1, 3, 1'b0);
      run_cmd("zero_w",       10,  2,  0,  7, 2, 0, 0, 1'b0);
      run_cmd("zero_h",       50, 40,  9,  0, 0, 1, 0, 1'b0);
      run_cmd("toggle_full",   0,  0, 12,  4, 3, 0, 1, 1'b0);
      run_cmd("clip_corner", 315, 238, 20, 10, 1, 1, 0, 1'b0);
      run_cmd("clip_x_out",  400,  5,  3,  2, 2, 1, 0, 1'b0);

      nxt_x = 100; nxt_y = 20; nxt_w = 7; nxt_h = 2; nxt_page = 3; nxt_pixel = 0;
      run_cmd("b2b_first",    30, 10,  4,  3, 1, 1, 0, 1'b1);
      run_cmd("b2b_second", nxt_x, nxt_y, nxt_w, nxt_h, nxt_page, nxt_pixel, 0, 1'b0);

      // Reset after the second word of a 10-row command.
      rst_words = 0;
      for (int c = 0; c < 5; c++) begin
         cmd_valid_i  = (c == 0);
         drive_cmd(7, 3, 4, 10, 2, 0);
         rst_i        = (c == 4);
         pfifo_full_i = (c == 4);
         #1;
         if (pfifo_we_o) begin
            check("rst_mid.word", pfifo_data_o, exp_word(7, 3, 4, 2, 0, rst_words));
            rst_words++;
         end
         @(posedge clk);
         #1;
      end
      rst_i        = 1'b0;
      pfifo_full_i = 1'b0;
      cmd_valid_i  = 1'b0;
      #1;
      check("rst_mid.words_before", 32'(rst_words),  32'd2);
      check("rst_mid.we_after",     32'(pfifo_we_o), 32'd0);
      check("rst_mid.ready_after",  32'(cmd_ready_o), 32'd1);
      check("rst_mid.busy_after",   32'(busy_o),     32'd0);
      check("rst_mid.done_after",   32'(done_o),     32'd0);
      check("rst_mid.data_after",   pfifo_data_o,    32'd0);
      run_cmd("after_reset", 20, 30, 6, 3, 1, 0, 0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         rx    = int'($urandom_range(0, 511));
         ry    = int'($urandom_range(0, 300));
         rw    = int'($urandom_range(0, 40));
         rh    = int'($urandom_range(0, 6));
         rpg   = int'($urandom_range(0, 3));
         rpx   = int'($urandom_range(0, 1));
         rmode = int'($urandom_range(0, 3));
         run_cmd("random", rx, ry, rw, rh, rpg, rpx, rmode, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
